// File: rtl/dmem_bus_if.sv
// Data-side bus interface for the memory-access stage: turns a RAM request into a
// registered req/ack bus transaction, stalls the pipeline, and returns/buffers load data.
module dmem_bus_if #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rd_buf;
    logic              r_err;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdata;

    logic              w_start;
    logic              w_ack;
    logic              w_timeout;
    logic              w_stall_req;
    logic [31:0]       w_cpu_data;

    assign w_start   = (r_state == IDLE) && cpu_ce_i && !flush_i;
    assign w_ack     = (r_state == BUSY) && bus_ack_i;
    // Flush wins over timeout: a killed access is not reported as a bus error.
    assign w_timeout = (r_state == BUSY) && !bus_ack_i && !flush_i && (r_cnt == LP_CNT_LAST);

    always_comb begin
        w_next      = r_state;
        w_stall_req = 1'b0;
        w_cpu_data  = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next      = BUSY;
                    w_stall_req = 1'b1;
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    if (flush_i) begin
                        w_next = IDLE;
                    end else begin
                        w_cpu_data = r_we ? 32'h0 : bus_rdata_i;
                        w_next     = stall_i ? WAIT_STALL : IDLE;
                    end
                end else if (flush_i || w_timeout) begin
                    w_next = IDLE;
                end else begin
                    w_stall_req = 1'b1;
                end
            end
            WAIT_STALL: begin
                w_cpu_data = r_rd_buf;
                if (!stall_i || flush_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rd_buf <= 32'h0;
            r_err    <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_sel    <= 4'h0;
            r_wdata  <= 32'h0;
        end else begin
            r_state <= w_next;
            r_err   <= w_timeout;
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= cpu_we_i;
                r_addr  <= cpu_addr_i;
                r_sel   <= cpu_sel_i;
                r_wdata <= cpu_data_i;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                if (bus_ack_i || flush_i || w_timeout) begin
                    r_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_ack) begin
                r_rd_buf <= (r_we || flush_i) ? 32'h0 : bus_rdata_i;
            end else if (w_timeout) begin
                r_rd_buf <= 32'h0;
            end
        end
    end

    // A request presented while reset is held must not stall the pipeline.
    assign stall_req_o = w_stall_req && rst;
    assign cpu_data_o  = w_cpu_data;
    assign bus_err_o   = r_err;
    assign bus_req_o   = r_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;

endmodule
